// File: rtl/mult_wide_seq_pkg.sv
// mult_wide_seq_pkg: shared FSM state encoding and width helpers for the wide multiplier
package mult_wide_seq_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  function automatic int loc_w(input int n);
    return $clog2(2 * n);
  endfunction
  function automatic int op_w(input int cw, input int n);
    return cw * n;
  endfunction
  function automatic int res_w(input int cw, input int n);
    return 2 * cw * n;
  endfunction
endpackage

// File: rtl/mult_wide_seq_chunk.sv
// mult_wide_seq_chunk: W x W unsigned multiplier with LAT register stages (ports: clk, reset_n, a, b -> p)
module mult_wide_seq_chunk #(
  parameter int W   = 32,
  parameter int LAT = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [2*W-1:0] p
);
  logic [2*W-1:0] pipe [LAT];
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      for (int s = 0; s < LAT; s++) pipe[s] <= '0;
    end else begin
      pipe[0] <= {{W{1'b0}}, a} * {{W{1'b0}}, b};
      for (int s = 1; s < LAT; s++) pipe[s] <= pipe[s-1];
    end
  assign p = pipe[LAT-1];
endmodule

// File: rtl/mult_wide_seq.sv
// mult_wide_seq: chunked sequential wide multiply / multiply-accumulate (ports: clk, reset_n, wr_*, start, op_acc, abort, rd_loc -> rd_val, busy, done, ovf)
module mult_wide_seq import mult_wide_seq_pkg::*; #(
  parameter int CHUNK_W  = 32,
  parameter int N_CHUNKS = 4,
  parameter int MULT_LAT = 2,
  localparam int LOC_W   = loc_w(N_CHUNKS)
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               wr_en,
  input  logic [LOC_W-1:0]   wr_loc,
  input  logic [CHUNK_W-1:0] wr_val,
  input  logic               start,
  input  logic               op_acc,
  input  logic               abort,
  input  logic [LOC_W-1:0]   rd_loc,
  output logic [CHUNK_W-1:0] rd_val,
  output logic               busy,
  output logic               done,
  output logic               ovf
);
  localparam int OP_W  = op_w(CHUNK_W, N_CHUNKS);
  localparam int RES_W = res_w(CHUNK_W, N_CHUNKS);
  localparam int DW    = $clog2(MULT_LAT + 1);
  localparam logic [LOC_W:0]   L2N  = (LOC_W+1)'(2 * N_CHUNKS);
  localparam logic [LOC_W-1:0] LN   = LOC_W'(N_CHUNKS);
  localparam logic [LOC_W-1:0] LAST = LOC_W'(N_CHUNKS - 1);
  state_t state, state_n;
  logic [OP_W-1:0]      a, b;
  logic [RES_W-1:0]     acc, rd_sh;
  logic [RES_W:0]       sum;
  logic [LOC_W-1:0]     i, j;
  logic [DW-1:0]        dcnt;
  logic [MULT_LAT-1:0]  vp;
  logic [LOC_W-1:0]     kp [MULT_LAT];
  logic [2*CHUNK_W-1:0] pp;
  logic go, kill, last_j, last;
  assign go     = state == IDLE && start && !abort;
  assign kill   = abort && busy;
  assign last_j = j == LAST;
  assign last   = last_j && i == LAST;
  assign busy   = state == RUN || state == DRAIN;
  assign done   = state == DONE;
  assign rd_sh  = acc >> (int'(rd_loc) * CHUNK_W);
  // Partial product is placed at its chunk offset; bit RES_W is the wrap-around carry.
  assign sum    = {1'b0, acc} + ({{(RES_W+1-2*CHUNK_W){1'b0}}, pp} << (int'(kp[MULT_LAT-1]) * CHUNK_W));
  mult_wide_seq_chunk #(.W(CHUNK_W), .LAT(MULT_LAT)) u_mul (
    .clk(clk),
    .reset_n(reset_n),
    .a(a[int'(i)*CHUNK_W +: CHUNK_W]),
    .b(b[int'(j)*CHUNK_W +: CHUNK_W]),
    .p(pp)
  );
  // DRAIN holds one cycle past the last pipeline exit so done lines up with rd_val reflecting the final acc.
  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    state_n = go ? RUN : IDLE;
      RUN:     state_n = last ? DRAIN : RUN;
      DRAIN:   state_n = dcnt == DW'(MULT_LAT) ? DONE : DRAIN;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (kill) state_n = IDLE;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state  <= IDLE;
      a      <= '0;
      b      <= '0;
      acc    <= '0;
      ovf    <= 1'b0;
      i      <= '0;
      j      <= '0;
      dcnt   <= '0;
      vp     <= '0;
      rd_val <= '0;
      for (int s = 0; s < MULT_LAT; s++) kp[s] <= '0;
    end else begin
      state  <= state_n;
      rd_val <= {1'b0, rd_loc} < L2N ? rd_sh[CHUNK_W-1:0] : '0;
      if (state == IDLE && wr_en && {1'b0, wr_loc} < L2N) begin
        if (wr_loc < LN) a[int'(wr_loc)*CHUNK_W +: CHUNK_W] <= wr_val;
        else b[(int'(wr_loc)-N_CHUNKS)*CHUNK_W +: CHUNK_W] <= wr_val;
      end
      vp[0] <= state == RUN;
      kp[0] <= i + j;
      for (int s = 1; s < MULT_LAT; s++) begin
        vp[s] <= vp[s-1];
        kp[s] <= kp[s-1];
      end
      if (vp[MULT_LAT-1]) begin
        acc <= sum[RES_W-1:0];
        ovf <= ovf | sum[RES_W];
      end
      if (state == RUN) begin
        j <= last_j ? '0 : j + 1'b1;
        i <= last_j ? i + 1'b1 : i;
      end
      dcnt <= state == DRAIN ? dcnt + 1'b1 : '0;
      if (go) begin
        acc <= op_acc ? acc : '0;
        ovf <= 1'b0;
        i   <= '0;
        j   <= '0;
      end
      if (kill) begin
        vp  <= '0;
        acc <= '0;
        ovf <= 1'b0;
      end
    end
endmodule

// File: tb/tb_mult_wide_seq.sv
// tb_mult_wide_seq: scoreboard bench for mult_wide_seq at default and small parameter sets
module tb_mult_wide_seq;
  typedef struct {
    logic [255:0] res;
    logic         ovf;
  } exp_t;
  exp_t sb [$];
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic wr_en = 1'b0, start = 1'b0, op_acc = 1'b0, abort = 1'b0;
  logic [2:0] wr_loc = '0, rd_loc = '0;
  logic [31:0] wr_val = '0, rd_val;
  logic busy, done, ovf;
  logic w2_en = 1'b0, start2 = 1'b0, op_acc2 = 1'b0;
  logic [2:0] w2_loc = '0, rd2_loc = '0;
  logic [7:0] w2_val = '0, rd2_val;
  logic busy2, done2, ovf2;
  logic [255:0] m1 = '0;
  logic [47:0]  m2 = '0;
  int n_chk = 0, n_pass = 0, n_done = 0, n_done2 = 0;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (done) n_done <= n_done + 1;
    if (done2) n_done2 <= n_done2 + 1;
  end
  mult_wide_seq dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_loc(wr_loc), .wr_val(wr_val),
    .start(start), .op_acc(op_acc), .abort(abort), .rd_loc(rd_loc), .rd_val(rd_val),
    .busy(busy), .done(done), .ovf(ovf)
  );
  mult_wide_seq #(.CHUNK_W(8), .N_CHUNKS(3), .MULT_LAT(1)) dut2 (
    .clk(clk), .reset_n(reset_n), .wr_en(w2_en), .wr_loc(w2_loc), .wr_val(w2_val),
    .start(start2), .op_acc(op_acc2), .abort(1'b0), .rd_loc(rd2_loc), .rd_val(rd2_val),
    .busy(busy2), .done(done2), .ovf(ovf2)
  );
  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic load1(input logic [127:0] x, input logic [127:0] y);
    for (int l = 0; l < 8; l++) begin
      @(negedge clk);
      wr_en = 1'b1;
      wr_loc = 3'(l);
      wr_val = l < 4 ? x[l*32 +: 32] : y[(l-4)*32 +: 32];
    end
    @(negedge clk);
    wr_en = 1'b0;
  endtask
  task automatic op1(input logic [127:0] x, input logic [127:0] y, input bit acc, input int inj, input bit ld);
    logic [256:0] s;
    exp_t e;
    int lat, nd0;
    if (ld) load1(x, y);
    s = {1'b0, acc ? m1 : 256'b0} + {1'b0, 256'(x) * 256'(y)};
    m1 = s[255:0];
    sb.push_back('{res: s[255:0], ovf: s[256]});
    nd0 = n_done;
    @(negedge clk);
    start = 1'b1;
    op_acc = acc;
    @(posedge clk);
    #1 start = 1'b0;
    check("busy_on_start", busy, 1);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (c == inj) begin
        start = 1'b1;
        wr_en = 1'b1;
        wr_loc = 3'd0;
        wr_val = 32'hDEADBEEF;
      end else if (c == inj + 1) begin
        start = 1'b0;
        wr_en = 1'b0;
      end
      if (done) begin
        lat = c;
        break;
      end
    end
    check("done_latency", lat, 19);
    check("busy_at_done", busy, 0);
    e = sb.pop_front();
    for (int l = 0; l < 8; l++) begin
      @(negedge clk);
      rd_loc = 3'(l);
      @(posedge clk);
      #1 check($sformatf("res_loc%0d", l), rd_val, e.res[l*32 +: 32]);
    end
    check("ovf", ovf, e.ovf);
    check("one_done", n_done - nd0, 1);
  endtask
  task automatic op2(input logic [23:0] x, input logic [23:0] y, input bit acc);
    logic [48:0] s;
    logic [63:0] r;
    exp_t e;
    int lat;
    for (int l = 0; l < 6; l++) begin
      @(negedge clk);
      w2_en = 1'b1;
      w2_loc = 3'(l);
      w2_val = l < 3 ? x[l*8 +: 8] : y[(l-3)*8 +: 8];
    end
    @(negedge clk);
    w2_en = 1'b0;
    s = {1'b0, acc ? m2 : 48'b0} + {1'b0, 48'(x) * 48'(y)};
    m2 = s[47:0];
    sb.push_back('{res: 256'(s[47:0]), ovf: s[48]});
    start2 = 1'b1;
    op_acc2 = acc;
    @(posedge clk);
    #1 start2 = 1'b0;
    lat = -1;
    for (int c = 1; c <= 30; c++) begin
      @(posedge clk);
      #1;
      if (done2) begin
        lat = c;
        break;
      end
    end
    check("mac_latency", lat, 11);
    e = sb.pop_front();
    for (int l = 0; l < 8; l++) begin
      @(negedge clk);
      rd2_loc = 3'(l);
      @(posedge clk);
      #1 r[l*8 +: 8] = rd2_val;
    end
    check("mac_res", r[47:0], e.res);
    check("mac_oor_zero", r[63:48], 0);
    check("mac_ovf", ovf2, e.ovf);
  endtask
  initial begin
    logic [127:0] ones;
    int nd0;
    ones = '1;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_rd_val", rd_val, 0);
    check("rst_ovf", ovf, 0);
    reset_n = 1'b1;
    op1(128'd1, 128'd1, 1'b0, 0, 1'b1);
    op1(ones, ones, 1'b0, 0, 1'b1);
    op1(ones, ones, 1'b1, 0, 1'b0);
    op1(128'd1, 128'd1, 1'b0, 4, 1'b1);
    op1(128'd1, 128'd1, 1'b0, 0, 1'b0);
    @(negedge clk);
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("start_abort_noop", busy, 0);
    load1(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'hffff_0000_aaaa_5555_1357_9bdf_2468_ace0);
    nd0 = n_done;
    @(negedge clk);
    start = 1'b1;
    op_acc = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (5) @(posedge clk);
    #1 abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    check("abort_busy", busy, 0);
    repeat (25) @(posedge clk);
    #1 check("abort_no_done", n_done - nd0, 0);
    for (int l = 0; l < 8; l++) begin
      @(negedge clk);
      rd_loc = 3'(l);
      @(posedge clk);
      #1 check($sformatf("abort_loc%0d", l), rd_val, 0);
    end
    check("abort_ovf", ovf, 0);
    m1 = '0;
    op1(128'h1234_5678_9abc_def0_0fed_cba9_8765_4321, 128'hffff_0000_aaaa_5555_1357_9bdf_2468_ace0, 1'b0, 0, 1'b1);
    rd_loc = 3'd3;
    @(negedge clk);
    start = 1'b1;
    op_acc = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    #1 reset_n = 1'b0;
    #1;
    check("rstrun_busy", busy, 0);
    check("rstrun_done", done, 0);
    check("rstrun_rd_val", rd_val, 0);
    @(negedge clk);
    reset_n = 1'b1;
    m1 = '0;
    m2 = '0;
    op1(128'd1, 128'd1, 1'b1, 0, 1'b1);
    for (int n = 0; n < 1000; n++)
      op2(24'($urandom), 24'($urandom), 1'($urandom_range(0, 1)));
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
